branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
Parametrised, registered successor to the combinational branch decision logic. It keeps its own flag register and resolves conditional and unconditional branches, plus CALL/RET through a return-address stack (RAS). It drives a one-cycle PC redirect and squashes wrong-path slots for a programmable number of cycles. It sits between decode and the PC register, in place of the combinational unit.

Parameters:
ADDR_W, 16, width of PC, offset and targets.
RAS_DEPTH, 4, number of return-address entries (power of two, at least 2).
SQUASH_CYCLES, 1, cycles br_ready stays low after a taken branch (at least 1).

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
br_valid  in  1  a branch/CALL/RET is presented this cycle.
br_ready  out  1  unit accepts br_valid this cycle.
br_type  in  4  opcode from the shared defines header.
br_offset  in  ADDR_W  two's-complement PC-relative offset.
pc_current  in  ADDR_W  PC of the presented instruction.
flags_in  in  4  ALU flags {V,C,N,Z} (bit0 Z, bit1 N, bit2 C, bit3 V).
flags_we  in  1  latch flags_in into the flag register.
res_valid  out  1  one-cycle pulse: a resolution is on the res_* outputs.
res_taken  out  1  resolution is taken; feeds PC.branch_en.
res_target  out  ADDR_W  redirect address; feeds PC.branch_addr.
ras_ovf  out  1  sticky: CALL occurred while RAS was full.
ras_unf  out  1  sticky: RET occurred while RAS was empty.
err_clr  in  1  clears ras_ovf and ras_unf.

Behaviour:
- Reset (async, rst_n=0):
  - res_valid, res_taken, res_target, ras_ovf, ras_unf = 0; br_ready = 1.
  - flags_q = 0; RAS empty (count=0, ptr=0); FSM in IDLE.
  - Reset asserted mid-squash returns to IDLE immediately.
- Flag register: flags_q <= flags_in on flags_we. Effective flags eff = flags_we ? flags_in : flags_q. This forwards same-cycle ALU flags.
- Accept: accept = br_valid & br_ready. Latency is 1 cycle: res_* are registered, and res_valid pulses in the cycle after accept.
- Condition, per br_type:
  - JMP: 1.
  - BRZ: eff[0]. BRNZ: ~eff[0].
  - BRNS: ~eff[1]. BRS: eff[1].
  - BRC: eff[2].
  - CALL: 1.
  - RET: 1 if RAS non-empty, else 0.
  - Any other opcode: res_valid=1, res_taken=0, no state change.
- Target:
  - Non-RET: pc_current + br_offset, truncated to ADDR_W (wraps modulo 2^ADDR_W).
  - RET: the RAS top entry.
  - res_target is updated on every accept, taken or not.
- RAS:
  - CALL pushes pc_current+1 (wrapping).
  - CALL when full: the oldest entry is overwritten (circular buffer), count stays at RAS_DEPTH, ras_ovf is set.
  - RET when non-empty: pops.
  - RET when empty: not taken, no pop, ras_unf is set.
  - err_clr in the same cycle as a new error: the error set wins.
- FSM:
  - IDLE: br_ready=1. On an accept with taken condition, go to SQUASH with cnt=SQUASH_CYCLES-1. A not-taken accept stays in IDLE.
  - SQUASH: br_ready=0, cnt decrements; return to IDLE when cnt==0.
  - br_valid while br_ready=0 is ignored: no RAS/flag-register effect except flags_we. Upstream must not expect it to be consumed.
- Outputs between resolutions: res_valid=0; res_taken and res_target hold their last value.

Decomposition:
- Shared defines header gains OP_BRS, OP_BRC, OP_CALL, OP_RET alongside the existing JMP/BRZ/BRNZ/BRNS codes, plus flag bit-index constants FLAG_Z/N/C/V.
- FSM state encodings are localparams in the module.
- One sub-module, ras_stack: parametrised by ADDR_W and RAS_DEPTH; push/pop/top/empty/full; overwrite-oldest when full.

Test Plan:
- Reset, then flags_we with flags_in=4'b0001 and BRZ in the same cycle, pc=16'h0010, offset=16'h0005 -> next cycle res_valid=1, res_taken=1, res_target=16'h0015; br_ready=0 for 1 cycle.
- flags_q=0, BRNZ with pc=16'hFFFE, offset=16'h0004 -> res_taken=1, res_target=16'h0002 (wrap). Same flags, BRZ -> res_taken=0, br_ready stays 1.
- CALL at pc=16'h0100, then RET -> RET resolves with res_taken=1, res_target=16'h0101. A second RET -> res_taken=0, ras_unf=1. err_clr -> ras_unf=0.
- Five CALLs at pc=1..5 with RAS_DEPTH=4 -> ras_ovf=1. Four RETs give targets 6,5,4,3, then the next RET is empty.
- SQUASH_CYCLES=3: taken JMP, then hold br_valid high -> br_ready low for exactly 3 cycles, with no res_valid during them.
- rst_n pulled low during SQUASH with the RAS holding 2 entries -> br_ready=1 immediately, a RET after release is not taken, and all outputs are 0.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit_pkg
// Shared branch opcodes and ALU flag bit positions used by the branch
// resolve unit and anything that drives it (decode, testbenches).
//   OP_*    : 4-bit br_type encodings. Any other value is an unknown opcode,
//             which resolves as not taken.
//   FLAG_*  : bit positions inside the 4-bit {V,C,N,Z} flag vector.
// ---------------------------------------------------------------------------
package branch_resolve_unit_pkg;

    localparam logic [3:0] OP_JMP  = 4'h1;
    localparam logic [3:0] OP_BRZ  = 4'h2;
    localparam logic [3:0] OP_BRNZ = 4'h3;
    localparam logic [3:0] OP_BRNS = 4'h4;
    localparam logic [3:0] OP_BRS  = 4'h5;
    localparam logic [3:0] OP_BRC  = 4'h6;
    localparam logic [3:0] OP_CALL = 4'h7;
    localparam logic [3:0] OP_RET  = 4'h8;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

endpackage

// File: rtl/branch_resolve_unit_ras_stack.sv
// ---------------------------------------------------------------------------
// ras_stack
// Circular return-address stack. A push when full overwrites the oldest entry
// and the count saturates at RAS_DEPTH, so the newest RAS_DEPTH return
// addresses are always retained.
//   clk, rst_n   : clock, asynchronous active-low reset
//   push_i       : write push_data_i as the new top
//   pop_i        : discard the top entry (caller only pops when non-empty)
//   push_data_i  : return address to push
//   top_o        : current top entry, 0 when empty
//   empty_o      : no entries held
//   full_o       : RAS_DEPTH entries held
// ---------------------------------------------------------------------------
module ras_stack #(
    parameter int ADDR_W    = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] push_data_i,
    output logic [ADDR_W-1:0] top_o,
    output logic              empty_o,
    output logic              full_o
);

    localparam int PTR_W = $clog2(RAS_DEPTH);

    logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_q;      // next slot to write
    logic [PTR_W:0]    cnt_q;
    logic [PTR_W-1:0]  top_idx;

    assign top_idx = ptr_q - PTR_W'(1);
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (PTR_W+1)'(RAS_DEPTH));
    assign top_o   = empty_o ? '0 : mem_q[top_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (push_i) begin
            // Power-of-two depth: the pointer wraps naturally onto the oldest slot.
            mem_q[ptr_q] <= push_data_i;
            ptr_q        <= ptr_q + PTR_W'(1);
            if (!full_o) begin
                cnt_q <= cnt_q + (PTR_W+1)'(1);
            end
        end else if (pop_i && !empty_o) begin
            ptr_q <= top_idx;
            cnt_q <= cnt_q - (PTR_W+1)'(1);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
// Registered branch resolver between decode and the PC register. Keeps its own
// flag register, resolves conditional/unconditional branches and CALL/RET via
// a return-address stack, and blocks new branches for SQUASH_CYCLES cycles
// after a taken resolution.
//   clk, rst_n           : clock, asynchronous active-low reset
//   br_valid / br_ready  : handshake; a branch is accepted when both are high
//                          in the same cycle. While br_ready is low br_valid is
//                          ignored and nothing is consumed.
//   br_type, br_offset, pc_current : presented instruction
//   flags_in, flags_we   : ALU flags {V,C,N,Z}; forwarded in the same cycle
//   res_valid            : one-cycle pulse the cycle after an accept
//   res_taken, res_target: resolution, held between pulses
//   ras_ovf, ras_unf     : sticky RAS overflow / underflow, cleared by err_clr
//   dbg_state            : FSM state (0 idle, 1 squash)
//   dbg_flags            : flag register contents
// ---------------------------------------------------------------------------
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int ADDR_W        = 16,
    parameter int RAS_DEPTH     = 4,
    parameter int SQUASH_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [3:0]        br_type,
    input  logic [ADDR_W-1:0] br_offset,
    input  logic [ADDR_W-1:0] pc_current,
    input  logic [3:0]        flags_in,
    input  logic              flags_we,
    output logic              res_valid,
    output logic              res_taken,
    output logic [ADDR_W-1:0] res_target,
    output logic              ras_ovf,
    output logic              ras_unf,
    input  logic              err_clr,
    output logic              dbg_state,
    output logic [3:0]        dbg_flags
);

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_SQUASH = 1'b1;
    localparam int   CNT_W     = (SQUASH_CYCLES > 1) ? $clog2(SQUASH_CYCLES) : 1;

    logic              state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [3:0]        flags_q;
    logic              res_valid_q, res_taken_q, ras_ovf_q, ras_unf_q;
    logic [ADDR_W-1:0] res_target_q;

    logic [2:0]        eff_znc;    // V is latched but no opcode tests it
    logic              accept, cond, push, pop, ovf_set, unf_set;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_empty, ras_full;

    assign br_ready = (state_q == ST_IDLE);
    assign accept   = br_valid & br_ready;
    assign eff_znc  = flags_we ? flags_in[2:0] : flags_q[2:0];

    always_comb begin
        cond    = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        target  = pc_current + br_offset;
        case (br_type)
            OP_JMP:  cond = 1'b1;
            OP_BRZ:  cond = eff_znc[FLAG_Z];
            OP_BRNZ: cond = ~eff_znc[FLAG_Z];
            OP_BRNS: cond = ~eff_znc[FLAG_N];
            OP_BRS:  cond = eff_znc[FLAG_N];
            OP_BRC:  cond = eff_znc[FLAG_C];
            OP_CALL: begin
                cond    = 1'b1;
                push    = accept;
                ovf_set = accept & ras_full;
            end
            OP_RET: begin
                cond    = ~ras_empty;
                target  = ras_top;
                pop     = accept & ~ras_empty;
                unf_set = accept & ras_empty;
            end
            default: cond = 1'b0;
        endcase
    end

    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (pc_current + ADDR_W'(1)),
        .top_o       (ras_top),
        .empty_o     (ras_empty),
        .full_o      (ras_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            flags_q      <= '0;
            res_valid_q  <= 1'b0;
            res_taken_q  <= 1'b0;
            res_target_q <= '0;
            ras_ovf_q    <= 1'b0;
            ras_unf_q    <= 1'b0;
        end else begin
            if (flags_we) begin
                flags_q <= flags_in;
            end
            // A new error in the same cycle as err_clr stays set.
            ras_ovf_q   <= ovf_set | (ras_ovf_q & ~err_clr);
            ras_unf_q   <= unf_set | (ras_unf_q & ~err_clr);
            res_valid_q <= accept;
            if (accept) begin
                res_taken_q  <= cond;
                res_target_q <= target;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept && cond) begin
                        state_q <= ST_SQUASH;
                        cnt_q   <= CNT_W'(SQUASH_CYCLES - 1);
                    end
                end
                default: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign res_valid  = res_valid_q;
    assign res_taken  = res_taken_q;
    assign res_target = res_target_q;
    assign ras_ovf    = ras_ovf_q;
    assign ras_unf    = ras_unf_q;
    assign dbg_state  = state_q;
    assign dbg_flags  = flags_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_unit
// Scoreboard bench: the stimulus process runs a reference model each cycle and
// queues the expected resolution and status; a negedge monitor compares.
// ---------------------------------------------------------------------------
module tb_branch_resolve_unit;
    import branch_resolve_unit_pkg::*;

    localparam int AW = 16;
    localparam int DEPTH = 4;
    localparam int SQ = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          br_valid = 1'b0;
    logic          br_ready;
    logic [3:0]    br_type = '0;
    logic [AW-1:0] br_offset = '0;
    logic [AW-1:0] pc_current = '0;
    logic [3:0]    flags_in = '0;
    logic          flags_we = 1'b0;
    logic          res_valid, res_taken, ras_ovf, ras_unf, err_clr = 1'b0;
    logic [AW-1:0] res_target;
    logic          dbg_state;
    logic [3:0]    dbg_flags;

    branch_resolve_unit #(
        .ADDR_W(AW), .RAS_DEPTH(DEPTH), .SQUASH_CYCLES(SQ)
    ) dut (
        .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(br_ready),
        .br_type(br_type), .br_offset(br_offset), .pc_current(pc_current),
        .flags_in(flags_in), .flags_we(flags_we), .res_valid(res_valid),
        .res_taken(res_taken), .res_target(res_target), .ras_ovf(ras_ovf),
        .ras_unf(ras_unf), .err_clr(err_clr), .dbg_state(dbg_state),
        .dbg_flags(dbg_flags)
    );

    always #5 clk = ~clk;

    // Scoreboard queues: {check_target, taken, target} and {ready, ovf, unf}.
    logic [AW+1:0] exp_q[$];
    logic [2:0]    stat_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [AW-1:0] m_ras[$];
    logic [3:0]    m_flags = '0;
    logic          m_ovf = 1'b0, m_unf = 1'b0;
    int            m_busy = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_ras.delete();
        m_flags = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_busy = 0;
    endtask

    // One clock of stimulus plus the reference model's view of that cycle.
    task automatic step(input logic v, input logic [3:0] t, input logic [AW-1:0] pc,
                        input logic [AW-1:0] off, input logic fwe, input logic [3:0] fin,
                        input logic clr);
        logic          rdy, acc, taken, chk_tgt, n_ovf, n_unf;
        logic [2:0]    eff;
        logic [AW-1:0] tgt;
        @(posedge clk);
        #1;
        br_valid = v; br_type = t; pc_current = pc; br_offset = off;
        flags_we = fwe; flags_in = fin; err_clr = clr;

        rdy = (m_busy == 0);
        stat_q.push_back({rdy, m_ovf, m_unf});
        eff = fwe ? fin[2:0] : m_flags[2:0];
        acc = v && rdy;
        n_ovf = m_ovf && !clr;
        n_unf = m_unf && !clr;
        if (m_busy > 0) m_busy--;
        if (acc) begin
            tgt = pc + off;
            chk_tgt = 1'b1;
            taken = 1'b0;
            if (t == OP_JMP) taken = 1'b1;
            else if (t == OP_BRZ) taken = eff[0];
            else if (t == OP_BRNZ) taken = !eff[0];
            else if (t == OP_BRNS) taken = !eff[1];
            else if (t == OP_BRS) taken = eff[1];
            else if (t == OP_BRC) taken = eff[2];
            else if (t == OP_CALL) begin
                taken = 1'b1;
                m_ras.push_back(pc + AW'(1));
                if (m_ras.size() > DEPTH) begin
                    void'(m_ras.pop_front());
                    n_ovf = 1'b1;
                end
            end else if (t == OP_RET) begin
                if (m_ras.size() > 0) begin
                    taken = 1'b1;
                    tgt = m_ras.pop_back();
                end else begin
                    tgt = '0;
                    n_unf = 1'b1;
                end
            end else begin
                chk_tgt = 1'b0;
            end
            exp_q.push_back({chk_tgt, taken, tgt});
            if (taken) m_busy = SQ;
        end
        if (fwe) m_flags = fin;
        m_ovf = n_ovf;
        m_unf = n_unf;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, '0, '0, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic br(input logic [3:0] t, input logic [AW-1:0] pc, input logic [AW-1:0] off);
        step(1'b1, t, pc, off, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(br_ready), 32'd1);
        chk({tag, "_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_taken"}, 32'(res_taken), 32'd0);
        chk({tag, "_target"}, 32'(res_target), 32'd0);
        chk({tag, "_ovf"}, 32'(ras_ovf), 32'd0);
        chk({tag, "_unf"}, 32'(ras_unf), 32'd0);
    endtask

    // Monitor
    always @(negedge clk) begin
        logic [2:0]    s;
        logic [AW+1:0] e;
        if (rst_n) begin
            if (stat_q.size() > 0) begin
                s = stat_q.pop_front();
                chk("br_ready", 32'(br_ready), 32'(s[2]));
                chk("ras_ovf", 32'(ras_ovf), 32'(s[1]));
                chk("ras_unf", 32'(ras_unf), 32'(s[0]));
            end
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_res_valid", 32'(res_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_taken", 32'(res_taken), 32'(e[AW]));
                    if (e[AW+1]) chk("res_target", 32'(res_target), 32'(e[AW-1:0]));
                end
            end
        end
    end

    initial begin
        logic [3:0] t;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Same-cycle flag forwarding into BRZ
        step(1'b1, OP_BRZ, 16'h0010, 16'h0005, 1'b1, 4'b0001, 1'b0);
        idle(SQ + 1);
        // Clear flags, BRNZ wrapping target, then a not-taken BRZ
        step(1'b0, 4'h0, '0, '0, 1'b1, 4'b0000, 1'b0);
        br(OP_BRNZ, 16'hFFFE, 16'h0004);
        idle(SQ + 1);
        br(OP_BRZ, 16'h0040, 16'h0010);
        br(OP_BRNS, 16'h0050, 16'hFFF0);
        idle(SQ + 1);
        // CALL/RET pair, then underflow and clear
        br(OP_CALL, 16'h0100, 16'h0020);
        idle(SQ);
        br(OP_RET, 16'h0000, 16'h0000);
        idle(SQ);
        br(OP_RET, 16'h0000, 16'h0000);
        idle(2);
        step(1'b0, 4'h0, '0, '0, 1'b0, 4'h0, 1'b1);
        idle(2);
        // Overflow: five CALLs, four RETs, one empty RET
        for (int i = 1; i <= 5; i++) begin
            br(OP_CALL, AW'(i), 16'h0100);
            idle(SQ);
        end
        for (int i = 0; i < 5; i++) begin
            br(OP_RET, 16'h0000, 16'h0000);
            idle(SQ);
        end
        // err_clr together with a new underflow: the error stays set
        step(1'b1, OP_RET, '0, '0, 1'b0, 4'h0, 1'b1);
        idle(2);
        step(1'b0, 4'h0, '0, '0, 1'b0, 4'h0, 1'b1);
        idle(1);
        // Taken JMP with br_valid held high through the squash window
        br(OP_JMP, 16'h0200, 16'h0010);
        for (int i = 0; i < SQ + 1; i++) br(OP_CALL, 16'h0300, 16'h0001);
        idle(SQ + 1);
        // Reset during squash with two RAS entries
        br(OP_CALL, 16'h0400, 16'h0002);
        idle(SQ);
        br(OP_CALL, 16'h0500, 16'h0002);
        idle(SQ);
        br(OP_JMP, 16'h0600, 16'h0003);
        idle(1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        br_valid = 1'b0;
        #1;
        check_reset_outputs("mid_squash_reset");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        br(OP_RET, 16'h0000, 16'h0000);
        idle(SQ + 1);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            t = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(1, 8)) : 4'($urandom_range(0, 15));
            step($urandom_range(0, 3) != 0, t, AW'($urandom), AW'($urandom),
                 $urandom_range(0, 2) == 0, 4'($urandom), $urandom_range(0, 15) == 0);
        end
        idle(SQ + 2);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        chk("drain_exp_q", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
